// File: rtl/weight_delta_outer.sv
// weight_delta_outer: backpropagation weight-update stage.
// Captures a delta vector and an activation vector. It then streams their
// outer product, scaled by 2^-LR_SHIFT, one weight-matrix row per handshake.
// Optional feature macro: WEIGHT_DELTA_SATURATE_EN. When it is defined,
// overflowing cells clamp to the output range. When it is undefined, they
// wrap in two's complement.
module weight_delta_outer #(
    parameter int ROWS           = 4,
    parameter int COLS           = 5,
    parameter int DELTA_WIDTH    = 8,
    parameter int ACT_WIDTH      = 8,
    parameter int RESULT_WIDTH   = 8,
    parameter int FRACTION_WIDTH = 4,
    parameter int LR_SHIFT       = 0,
    localparam int IDX_W         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ROWS*DELTA_WIDTH-1:0]  delta,
    input  logic                         delta_valid,
    output logic                         delta_ready,
    input  logic [COLS*ACT_WIDTH-1:0]    act,
    input  logic                         act_valid,
    output logic                         act_ready,
    output logic [COLS*RESULT_WIDTH-1:0] row,
    output logic [IDX_W-1:0]             row_index,
    output logic                         row_last,
    output logic                         row_valid,
    input  logic                         row_ready,
    output logic                         error
);

    localparam int PW    = DELTA_WIDTH + ACT_WIDTH;
    localparam int EW    = (RESULT_WIDTH > PW) ? RESULT_WIDTH : PW;
    localparam int SHIFT = FRACTION_WIDTH + LR_SHIFT;
    localparam logic [RESULT_WIDTH-1:0] RMAX = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic [RESULT_WIDTH-1:0] RMIN = {1'b1, {(RESULT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                         state;
    logic [ROWS*DELTA_WIDTH-1:0]    delta_buf;
    logic [COLS*ACT_WIDTH-1:0]      act_buf;
    logic                           delta_set;
    logic                           act_set;

    logic [DELTA_WIDTH-1:0]         d_cell;
    logic signed [EW-1:0]           prod;
    logic signed [EW-1:0]           shifted;
    logic                           ovf;
    logic                           ovf_any;
    logic [COLS*RESULT_WIDTH-1:0]   row_next;

    assign delta_ready = !delta_set;
    assign act_ready   = !act_set;

    // Current row: COLS parallel products of the selected delta cell, floor-shifted, range-checked.
    // Products are formed at width max(PW, RESULT_WIDTH). A cell fits when every bit from
    // the result sign bit upward is equal. When RESULT_WIDTH >= PW that span is a single
    // bit, so overflow never occurs.
    always_comb begin
        row_next = '0;
        ovf_any  = 1'b0;
        ovf      = 1'b0;
        d_cell   = '0;
        prod     = '0;
        shifted  = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (IDX_W'(r) == row_index)
                d_cell = delta_buf[r*DELTA_WIDTH +: DELTA_WIDTH];
        end
        for (int unsigned c = 0; c < COLS; c++) begin
            prod    = EW'($signed(d_cell)) * EW'($signed(act_buf[c*ACT_WIDTH +: ACT_WIDTH]));
            shifted = prod >>> SHIFT;
            ovf     = !((&shifted[EW-1:RESULT_WIDTH-1]) || !(|shifted[EW-1:RESULT_WIDTH-1]));
            ovf_any = ovf_any | ovf;
            row_next[c*RESULT_WIDTH +: RESULT_WIDTH] = shifted[RESULT_WIDTH-1:0];
`ifdef WEIGHT_DELTA_SATURATE_EN
            if (ovf)
                row_next[c*RESULT_WIDTH +: RESULT_WIDTH] = shifted[EW-1] ? RMIN : RMAX;
`endif
        end
    end

    // Input capture, batch sequencing and registered row outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            delta_buf <= '0;
            act_buf   <= '0;
            delta_set <= 1'b0;
            act_set   <= 1'b0;
            row       <= '0;
            row_index <= '0;
            row_last  <= 1'b0;
            row_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (delta_valid && !delta_set) begin
                delta_buf <= delta;
                delta_set <= 1'b1;
            end
            if (act_valid && !act_set) begin
                act_buf <= act;
                act_set <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (delta_set && act_set) begin
                        state     <= CALC;
                        error     <= 1'b0;
                        row_index <= '0;
                    end
                end
                CALC: begin
                    row       <= row_next;
                    row_valid <= 1'b1;
                    row_last  <= (row_index == IDX_W'(ROWS-1));
                    if (ovf_any)
                        error <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (row_ready) begin
                        row_valid <= 1'b0;
                        row_last  <= 1'b0;
                        if (row_index == IDX_W'(ROWS-1)) begin
                            delta_set <= 1'b0;
                            act_set   <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            row_index <= row_index + IDX_W'(1);
                            state     <= CALC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_delta_outer.sv
// Directed testbench for weight_delta_outer.
// It uses ROWS=2, COLS=3, 8-bit widths and FRACTION_WIDTH=4. A second
// instance uses LR_SHIFT=2.
module tb_weight_delta_outer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] delta;
    logic        delta_valid, delta_ready;
    logic [23:0] act;
    logic        act_valid, act_ready;
    logic [23:0] row;
    logic [0:0]  row_index;
    logic        row_last, row_valid, row_ready, error;

    logic [15:0] lr_delta;
    logic        lr_delta_valid, lr_delta_ready;
    logic [23:0] lr_act;
    logic        lr_act_valid, lr_act_ready;
    logic [23:0] lr_row;
    logic [0:0]  lr_row_index;
    logic        lr_row_last, lr_row_valid, lr_row_ready, lr_error;

    int checks = 0;
    int passes = 0;
    logic [23:0] held;
    logic [7:0]  ovf_cell;

    weight_delta_outer #(.ROWS(2), .COLS(3), .DELTA_WIDTH(8), .ACT_WIDTH(8),
                         .RESULT_WIDTH(8), .FRACTION_WIDTH(4), .LR_SHIFT(0)) dut (
        .clk(clk), .rst(rst),
        .delta(delta), .delta_valid(delta_valid), .delta_ready(delta_ready),
        .act(act), .act_valid(act_valid), .act_ready(act_ready),
        .row(row), .row_index(row_index), .row_last(row_last),
        .row_valid(row_valid), .row_ready(row_ready), .error(error)
    );

    weight_delta_outer #(.ROWS(2), .COLS(3), .DELTA_WIDTH(8), .ACT_WIDTH(8),
                         .RESULT_WIDTH(8), .FRACTION_WIDTH(4), .LR_SHIFT(2)) dut_lr (
        .clk(clk), .rst(rst),
        .delta(lr_delta), .delta_valid(lr_delta_valid), .delta_ready(lr_delta_ready),
        .act(lr_act), .act_valid(lr_act_valid), .act_ready(lr_act_ready),
        .row(lr_row), .row_index(lr_row_index), .row_last(lr_row_last),
        .row_valid(lr_row_valid), .row_ready(lr_row_ready), .error(lr_error)
    );

    function automatic logic [15:0] pk2(input logic signed [7:0] d0, input logic signed [7:0] d1);
        return {d1, d0};
    endfunction

    function automatic logic [23:0] pk3(input logic signed [7:0] c0, input logic signed [7:0] c1,
                                        input logic signed [7:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " row"}, 32'(row), 32'h0);
        check({tag, " idx"}, 32'(row_index), 32'h0);
        check({tag, " flags"}, {27'h0, row_valid, row_last, error, delta_ready, act_ready}, 32'h3);
    endtask

    initial begin
`ifdef WEIGHT_DELTA_SATURATE_EN
        ovf_cell = 8'sd127;
`else
        ovf_cell = 8'hF0;
`endif
        rst = 1'b1;
        delta = '0; delta_valid = 1'b0; act = '0; act_valid = 1'b0; row_ready = 1'b1;
        lr_delta = '0; lr_delta_valid = 1'b0; lr_act = '0; lr_act_valid = 1'b0; lr_row_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        check_reset_state("reset");

        // 1. Basic batch, both inputs in cycle 0.
        delta = pk2(16, -8); act = pk3(32, 8, -16);
        delta_valid = 1'b1; act_valid = 1'b1;
        step();                                   // cycle 1
        delta_valid = 1'b0; act_valid = 1'b0;
        check("b1 readies low", {30'h0, delta_ready, act_ready}, 32'h0);
        step();                                   // cycle 2
        check("b1 c2 no valid", 32'(row_valid), 32'h0);
        step();                                   // cycle 3
        check("b1 row0", 32'(row), 32'(pk3(32, 8, -16)));
        check("b1 row0 ctl", {29'h0, row_valid, row_last, row_index}, 32'h4);
        step(); step();                           // cycle 5
        check("b1 row1", 32'(row), 32'(pk3(-16, -4, 8)));
        check("b1 row1 ctl", {28'h0, row_valid, row_last, row_index, error}, 32'hE);
        step();                                   // cycle 6
        check("b1 readies", {29'h0, row_valid, delta_ready, act_ready}, 32'h3);

        // 2. Staggered inputs and backpressure.
        row_ready = 1'b0;
        act = pk3(16, -16, 48); act_valid = 1'b1;
        step();                                   // cycle 1
        act_valid = 1'b0;
        check("b2 act held", {30'h0, delta_ready, act_ready}, 32'h2);
        step(); step(); step();                   // cycle 4
        check("b2 act still held", 32'(act_ready), 32'h0);
        delta = pk2(32, 16); delta_valid = 1'b1;
        step();                                   // cycle 5
        delta_valid = 1'b0;
        step(); step();                           // cycle 7
        held = row;
        check("b2 row0", 32'(row), 32'(pk3(32, -32, 96)));
        for (int i = 0; i < 4; i++) begin
            step();
            check("b2 row0 stable", {7'h0, row_valid, row}, {8'h01, held});
        end
        step();                                   // cycle 12: 5 cycles stalled
        check("b2 row0 still", {7'h0, row_valid, row_index, row}, {7'h0, 1'b1, 1'b0, held} >> 0);
        row_ready = 1'b1;
        step();                                   // cycle 13
        check("b2 calc gap", 32'(row_valid), 32'h0);
        step();                                   // cycle 14
        check("b2 row1", 32'(row), 32'(pk3(16, -16, 48)));
        check("b2 row1 last", {30'h0, row_valid, row_last}, 32'h3);
        step();                                   // cycle 15

        // 3. Overflow, then 6. back-to-back batch.
        delta = pk2(127, 1); act = pk3(127, 0, 0);
        delta_valid = 1'b1; act_valid = 1'b1;
        step();
        delta_valid = 1'b0; act_valid = 1'b0;
        step(); step();                           // cycle 3
        check("ovf row0", 32'(row), 32'({8'h00, 8'h00, ovf_cell}));
        check("ovf error", 32'(error), 32'h1);
        step(); step();                           // cycle 5
        check("ovf row1", 32'(row), 32'(pk3(7, 0, 0)));
        check("ovf row1 last", {30'h0, row_last, error}, 32'h3);
        step();                                   // cycle 6: back-to-back
        check("b2b readies", {30'h0, delta_ready, act_ready}, 32'h3);
        delta = pk2(16, -8); act = pk3(32, 8, -16);
        delta_valid = 1'b1; act_valid = 1'b1;
        step();                                   // cycle 7
        delta_valid = 1'b0; act_valid = 1'b0;
        check("b2b accepted", {29'h0, error, delta_ready, act_ready}, 32'h4);
        step();                                   // cycle 8
        check("b2b err cleared", 32'(error), 32'h0);
        step();                                   // cycle 9
        check("b2b row0", {7'h0, row_valid, row}, {8'h01, pk3(32, 8, -16)});
        step(); step();                           // cycle 11
        check("b2b row1", 32'(row), 32'(pk3(-16, -4, 8)));
        step();

        // 5. Reset mid-batch after an overflowing row.
        row_ready = 1'b0;
        delta = pk2(127, 1); act = pk3(127, 0, 0);
        delta_valid = 1'b1; act_valid = 1'b1;
        step();
        delta_valid = 1'b0; act_valid = 1'b0;
        step(); step();
        check("rst pre valid err", {30'h0, row_valid, error}, 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("midrst");
        row_ready = 1'b1;
        delta = pk2(-16, 8); act = pk3(8, -8, 16);
        delta_valid = 1'b1; act_valid = 1'b1;
        step();
        delta_valid = 1'b0; act_valid = 1'b0;
        step(); step();
        check("fresh row0", {6'h0, row_valid, error, row}, {8'h02, pk3(-8, 8, -16)});
        step(); step();
        check("fresh row1", {6'h0, row_last, error, row}, {8'h02, pk3(4, -4, 8)});
        step();

        // 4. Learning rate 2^-2 with floor rounding.
        lr_delta = pk2(16, -1); lr_act = pk3(32, 1, 0);
        lr_delta_valid = 1'b1; lr_act_valid = 1'b1;
        step();
        lr_delta_valid = 1'b0; lr_act_valid = 1'b0;
        step(); step();
        check("lr row0", {7'h0, lr_row_valid, lr_row}, {8'h01, pk3(8, 0, 0)});
        step(); step();
        check("lr row1", {6'h0, lr_row_last, lr_error, lr_row}, {8'h02, pk3(-1, -1, 0)});
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/weight_delta_outer.md
# weight_delta_outer

Backpropagation weight-update stage placed directly downstream of the element-wise delta product. It captures one delta vector (the fixed-point product of error and activation derivative) and one activation vector from the previous layer. It then streams out the outer product scaled by a power-of-two learning rate, one weight-matrix row per handshake, to the weight-memory update logic.

## Interface
- `ROWS`, default 4: delta vector length, which is the number of output rows.
- `COLS`, default 5: activation vector length, which is the number of cells per row.
- `DELTA_WIDTH`, default 8: signed delta cell width.
- `ACT_WIDTH`, default 8: signed activation cell width.
- `RESULT_WIDTH`, default 8: signed output cell width.
- `FRACTION_WIDTH`, default 4: fraction bits, shared by all operands.
- `LR_SHIFT`, default 0: learning rate is 2^-LR_SHIFT, applied as an extra arithmetic right shift.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `delta`  in  ROWS*DELTA_WIDTH  delta vector; cell i is at bits [i*DELTA_WIDTH +: DELTA_WIDTH].
- `delta_valid` in 1, `delta_ready` out 1: delta handshake.
- `act`  in  COLS*ACT_WIDTH  activation vector, packed the same way.
- `act_valid` in 1, `act_ready` out 1: activation handshake.
- `row`  out  COLS*RESULT_WIDTH  current output row; cell c is at bits [c*RESULT_WIDTH +: RESULT_WIDTH].
- `row_index`  out  clog2(ROWS)  index of the row currently presented.
- `row_last`  out  1  high when row_index == ROWS-1 while row_valid is high.
- `row_valid` out 1, `row_ready` in 1: row handshake.
- `error`  out  1  sticky overflow flag for the current batch.

## Operation
- **Input capture.** Each input is held in its own buffer with a set flag.
  - A buffer is captured when `valid` is high and its set flag is low.
  - `delta_ready` = !delta_set and `act_ready` = !act_set.
  - The two inputs may arrive in either order or in the same cycle.
- **State machine.** Three states: IDLE, CALC, OUT.
  - **IDLE.** Captures inputs. Moves to CALC when both set flags are high. On that transition `error` and `row_index` are cleared.
  - **CALC.** Computes row r = row_index in a single cycle using COLS parallel multipliers. Cell c = (delta[r]*act[c]) >>> (FRACTION_WIDTH+LR_SHIFT), computed at full width DELTA_WIDTH+ACT_WIDTH, signed, with floor rounding. The result is registered into `row`, and the state moves to OUT.
  - **OUT.** `row_valid` is high.
    - On `row_ready` with r < ROWS-1: increment row_index and go to CALC.
    - On `row_ready` with r == ROWS-1: clear both set flags and go to IDLE.
    - Without `row_ready`: hold all outputs stable.
- **Overflow.** A cell overflows when its shifted value is outside the range [-2^(RESULT_WIDTH-1), 2^(RESULT_WIDTH-1)-1].
  - Any overflow in CALC sets `error`.
  - `error` stays high until the next IDLE→CALC transition.
  - If RESULT_WIDTH >= DELTA_WIDTH+ACT_WIDTH, `error` is constant 0.
- **Input buffer lifetime.** Input buffers are not overwritten while a batch is in progress.

## Timing
- **Reset values.** state=IDLE, both set flags=0, `delta_ready`=1, `act_ready`=1, `row`=0, `row_index`=0, `row_last`=0, `row_valid`=0, `error`=0.
  - A reset during CALC or OUT discards the batch. It takes effect at the next edge.
- **First-row latency.** If the second input is accepted in cycle 0: cycle 1 is IDLE with both flags set, cycle 2 is CALC, and `row_valid` is high in cycle 3.
- **Row throughput.** A row handshake in cycle n gives the next row's `row_valid` in cycle n+2. Peak rate is one row per 2 cycles.
- **Batch duration.** With `row_ready` tied high, a batch takes 2 + 2*ROWS cycles from acceptance of the second input to return to IDLE.
- **Input readiness.** After the last row handshake in cycle n, both readies are high in cycle n+1. A new batch may be accepted in that same cycle.
- **Early input.** An input that arrives early while the other is still missing is held. Its ready stays low until the batch completes.

## Configuration
- Macro: `WEIGHT_DELTA_SATURATE_EN`.
- **Defined:** an overflowing cell is clamped to 2^(RESULT_WIDTH-1)-1 or -2^(RESULT_WIDTH-1), matching its sign. `error` is still set.
- **Undefined:** an overflowing cell is truncated to its low RESULT_WIDTH bits (two's-complement wrap). `error` is set.
- **Both builds:** values that do not overflow are identical.

## Test plan
All scenarios use ROWS=2, COLS=3, all widths 8, FRACTION_WIDTH=4, LR_SHIFT=0 unless stated.
1. **Basic batch.**
   - Stimulus: delta=[16,-8], act=[32,8,-16], given in the same cycle, `row_ready` tied high.
   - Response: row0=[32,8,-16] with `row_index`=0 in cycle 3; row1=[-16,-4,8] with `row_last`=1 in cycle 5; `error`=0; readies high in cycle 6.
2. **Staggered inputs and backpressure.**
   - Stimulus: act is given 4 cycles before delta; `row_ready` is held low for 5 cycles after row0 appears.
   - Response: act_ready=0 from the cycle after act is accepted; row0 is held bit-stable; row1 appears 2 cycles after the row0 handshake.
3. **Overflow.**
   - Stimulus: delta=[127,1], act=[127,0,0].
   - Response: error=1. Cell (0,0) is 127 with `WEIGHT_DELTA_SATURATE_EN` defined, and -16 (0xF0) without it.
4. **Learning rate and rounding.**
   - Stimulus: LR_SHIFT=2, delta=[16,-1], act=[32,1,0].
   - Response: row0=[8,0,0]; row1=[-1,-1,0] (floor).
5. **Reset mid-batch.**
   - Stimulus: rst asserted for one cycle while row0 is waiting for `row_ready`.
   - Response: the next cycle shows all reset values. A fresh batch then produces correct rows, and `error` is cleared.
6. **Back-to-back batches.**
   - Stimulus: a new delta/act pair is presented in the cycle after the last row handshake.
   - Response: the pair is accepted immediately; the first row arrives 3 cycles later; the previous batch's `error` is cleared on the IDLE→CALC transition.
